// File: rtl/spi_pkg.sv
// Shared SPI link definitions: clock mode encoding and default word/queue geometry.
package spi_pkg;
  typedef enum logic [1:0] {MODE0 = 2'd0, MODE1 = 2'd1, MODE2 = 2'd2, MODE3 = 2'd3} spi_mode_e;

  localparam int DEF_WORD_W   = 32;
  localparam int DEF_TX_DEPTH = 4;

  // Mode number is {CPOL, CPHA}.
  function automatic spi_mode_e mode_of(input int cpol, input int cpha);
    return spi_mode_e'({cpol != 0, cpha != 0});
  endfunction

  function automatic logic samples_on_rise(input spi_mode_e m);
    return (m == MODE0) || (m == MODE3);
  endfunction
endpackage

// File: rtl/spi_tx_fifo.sv
// Power-of-two transmit word queue; head is visible combinationally, push ignored when full.
module spi_tx_fifo import spi_pkg::*; #(
  parameter int WIDTH = DEF_WORD_W,
  parameter int DEPTH = DEF_TX_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
endmodule

// File: rtl/spi_word_link.sv
// SPI slave moving whole words: oversampled SCLK/CS/MOSI, RX word register, queued TX words.
module spi_word_link import spi_pkg::*; #(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int TX_DEPTH = DEF_TX_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun
);
  localparam spi_mode_e      MODE        = mode_of(CPOL, CPHA);
  localparam bit             SAMPLE_RISE = samples_on_rise(MODE);
  localparam bit             IDLE_LVL    = (CPOL != 0);
  localparam bit             SKIP_FIRST  = (CPHA != 0);
  localparam int             CW          = $clog2(WORD_W);
  localparam int             FCW         = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0]  LAST_BIT    = CW'(WORD_W - 1);
  localparam logic [FCW-1:0] FIFO_MAX    = FCW'(TX_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e r_state, w_state_nxt;

  logic [1:0]        r_sclk_s, r_cs_s, r_mosi_s;
  logic              r_sclk_d, r_cs_d;
  logic              w_start, w_live, w_rise, w_fall, w_samp, w_shft, w_last, w_load;
  logic [CW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_rx_shift, r_rx_data, r_tx_shift, w_head;
  logic              r_rx_pend, r_rx_valid, r_word_done, r_skip, r_underrun;
  logic              w_full, w_empty, w_push;
  logic [FCW-1:0]    w_count;

  // CS syncs reset to "selected" so a frame still running at reset release shows no CS fall.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sclk_s <= {2{IDLE_LVL}};
      r_sclk_d <= IDLE_LVL;
      r_cs_s   <= 2'b00;
      r_cs_d   <= 1'b0;
      r_mosi_s <= 2'b00;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_sclk_d <= r_sclk_s[1];
      r_cs_s   <= {r_cs_s[0], cs};
      r_cs_d   <= r_cs_s[1];
      r_mosi_s <= {r_mosi_s[0], mosi};
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE:    if (r_cs_d && !r_cs_s[1]) begin
                 w_state_nxt = ACTIVE;
                 w_start     = 1'b1;
               end
      ACTIVE:  if (r_cs_s[1]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_live = (r_state == ACTIVE) && !r_cs_s[1];
  assign w_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_samp = w_live & (SAMPLE_RISE ? w_rise : w_fall);
  assign w_shft = w_live & (SAMPLE_RISE ? w_fall : w_rise);
  assign w_last = w_samp & (r_bit_cnt == LAST_BIT);
  assign w_load = w_start | (w_shft & r_word_done);

  assign w_push   = tx_valid & (w_count != FIFO_MAX);
  assign tx_ready = ~w_full;

  spi_tx_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .i_push(w_push), .i_data(tx_data), .i_pop(w_load),
    .o_head(w_head), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_pend  <= w_last;
      r_rx_valid <= r_rx_pend;
      if (!w_live) begin
        r_bit_cnt <= '0;
      end else if (w_samp) begin
        r_rx_shift <= {r_rx_shift[WORD_W-2:0], r_mosi_s[1]};
        r_bit_cnt  <= w_last ? '0 : r_bit_cnt + 1'b1;
        if (w_last) r_rx_data <= {r_rx_shift[WORD_W-2:0], r_mosi_s[1]};
      end
    end

  // A word start loads the queue head (or zeros when empty); with CPHA=1 the word's first
  // shift edge only starts the bit, so it is skipped at frame entry and consumed by later loads.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tx_shift  <= '0;
      r_word_done <= 1'b0;
      r_skip      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_load & w_empty;
      if (!w_live && !w_start) begin
        r_tx_shift  <= '0;
        r_word_done <= 1'b0;
        r_skip      <= 1'b0;
      end else begin
        if (w_last) r_word_done <= 1'b1;
        if (w_load) begin
          r_tx_shift  <= w_empty ? '0 : w_head;
          r_word_done <= 1'b0;
          r_skip      <= SKIP_FIRST & w_start;
        end else if (w_shft) begin
          if (r_skip) r_skip     <= 1'b0;
          else        r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
        end
      end
    end

  assign miso        = r_tx_shift[WORD_W-1];
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
endmodule

// File: tb/tb_spi_word_link.sv
// Drives one link per SPI mode as the MCU would and checks words against a queue model.
module tb_spi_word_link;
  localparam int N     = 4;
  localparam int HALF  = 4;
  localparam int DEPTH = 4;

  logic               clk      = 1'b0;
  logic               reset    = 1'b1;
  logic [N-1:0]       sclk     = 4'b1100;
  logic [N-1:0]       cs       = 4'hF;
  logic [N-1:0]       mosi     = '0;
  logic [N-1:0]       tx_valid = '0;
  logic [N-1:0][31:0] tx_data  = '0;
  logic               miso        [N];
  logic               rx_valid    [N];
  logic               tx_ready    [N];
  logic               tx_underrun [N];
  logic [31:0]        rx_data     [N];

  int          n_chk = 0;
  int          n_err = 0;
  int          rxv_cnt [N];
  int          unr_cnt [N];
  logic [31:0] mq   [N][DEPTH];
  int          mcnt [N];
  logic [31:0] mrx  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : 16;
    logic [W-1:0] w_rx;
    spi_word_link #(.WORD_W(W), .CPOL(g / 2), .CPHA(g % 2), .TX_DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk[g]), .cs(cs[g]), .mosi(mosi[g]), .miso(miso[g]),
      .rx_data(w_rx), .rx_valid(rx_valid[g]), .tx_data(tx_data[g][W-1:0]),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_underrun(tx_underrun[g])
    );
    assign rx_data[g] = 32'(w_rx);
  end

  always @(negedge clk)
    for (int m = 0; m < N; m++) begin
      if (rx_valid[m] === 1'b1)    rxv_cnt[m]++;
      if (tx_underrun[m] === 1'b1) unr_cnt[m]++;
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input logic [31:0] d);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    chk($sformatf("ready%0d", m), tx_ready[m], mcnt[m] < DEPTH);
    tick(1);
    tx_valid[m] = 1'b0;
    if (mcnt[m] < DEPTH) begin
      mq[m][mcnt[m]] = d;
      mcnt[m]++;
    end
  endtask

  // MCU side: bits go out in order mo[63], mo[62], ...; miso sampled into mi the same way.
  // The MCU deselects before returning SCLK to idle.
  task automatic frame(input int m, input int nbits, input logic [63:0] mo, output logic [63:0] mi);
    logic idle;
    bit   cpha;
    idle  = (m / 2) != 0;
    cpha  = (m % 2) != 0;
    mi    = '0;
    cs[m] = 1'b0;
    if (!cpha) mosi[m] = mo[63];
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mi[63 - i] = miso[m];
        sclk[m] = ~idle;
        tick(HALF);
        if (i < nbits - 1) begin
          sclk[m] = idle;
          mosi[m] = mo[62 - i];
          tick(HALF);
        end
      end else begin
        sclk[m] = ~idle;
        mosi[m] = mo[63 - i];
        tick(HALF);
        mi[63 - i] = miso[m];
        sclk[m] = idle;
        tick(HALF);
      end
    end
    cs[m] = 1'b1;
    tick(HALF);
    sclk[m] = idle;
    tick(8);
  endtask

  task automatic run_frame(input string tag, input int m, input int nbits, input logic [63:0] mo);
    int          w, nslot, nw, rv0, un0, exp_unr;
    logic [63:0] mi, exp_mi, sh;
    logic [31:0] d;
    w       = (m == 0) ? 32 : 16;
    exp_mi  = '0;
    exp_unr = 0;
    nslot   = 1 + (nbits - 1) / w;
    for (int s = 0; s < nslot; s++) begin
      if (mcnt[m] > 0) begin
        d = mq[m][0];
        for (int k = 1; k < DEPTH; k++) mq[m][k-1] = mq[m][k];
        mcnt[m]--;
      end else begin
        d = '0;
        exp_unr++;
      end
      for (int b = 0; b < w; b++)
        if (s * w + b < nbits) exp_mi[63 - (s * w + b)] = d[w - 1 - b];
    end
    nw = nbits / w;
    if (nw > 0) begin
      sh     = mo << ((nw - 1) * w);
      mrx[m] = sh[63:32] >> (32 - w);
    end
    rv0 = rxv_cnt[m];
    un0 = unr_cnt[m];
    frame(m, nbits, mo, mi);
    chk({tag, ".miso"}, mi, exp_mi);
    chk({tag, ".rxv"}, 64'(rxv_cnt[m] - rv0), 64'(nw));
    chk({tag, ".unr"}, 64'(unr_cnt[m] - un0), 64'(exp_unr));
    chk({tag, ".rxd"}, rx_data[m], mrx[m]);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int m = 0; m < N; m++) begin
      chk($sformatf("%s.miso%0d", tag, m), miso[m], 0);
      chk($sformatf("%s.rxv%0d", tag, m), rx_valid[m], 0);
      chk($sformatf("%s.unr%0d", tag, m), tx_underrun[m], 0);
      chk($sformatf("%s.rxd%0d", tag, m), rx_data[m], 0);
      chk($sformatf("%s.rdy%0d", tag, m), tx_ready[m], 1);
    end
  endtask

  initial begin
    int m, w, nw, nbits, rv0, un0;
    for (int i = 0; i < N; i++) begin
      mrx[i]  = '0;
      mcnt[i] = 0;
    end
    tick(4);
    chk_reset_vals("por");
    reset = 1'b0;
    tick(4);

    run_frame("beef", 0, 32, {32'hDEADBEEF, 32'h0});

    push(0, 32'h12345678);
    push(0, 32'hCAFEF00D);
    run_frame("two", 0, 64, {$urandom, $urandom});

    run_frame("empty", 0, 32, {$urandom, 32'h0});

    for (int i = 0; i < 4; i++) push(0, $urandom);
    chk("full.ready", tx_ready[0], 0);
    push(0, 32'hBAD0BAD0);
    run_frame("drain1", 0, 32, {$urandom, 32'h0});
    chk("drain.ready", tx_ready[0], 1);
    run_frame("drain2", 0, 64, {$urandom, $urandom});

    run_frame("part17", 0, 17, {$urandom, $urandom});
    run_frame("after17", 0, 32, {$urandom, 32'h0});

    for (int i = 1; i < N; i++) begin
      push(i, 32'h0000A55A);
      run_frame($sformatf("a55a_m%0d", i), i, 16, {16'hA55A, 48'h0});
    end

    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(0, N - 1);
      w = (m == 0) ? 32 : 16;
      for (int k = $urandom_range(0, 3); k > 0; k--)
        push(m, (m == 0) ? $urandom : ($urandom & 32'hFFFF));
      nw    = $urandom_range(1, 64 / w);
      nbits = nw * w;
      if ($urandom_range(0, 1) == 1) nbits += $urandom_range(1, w - 1);
      if (nbits > 64) nbits = 64;
      run_frame($sformatf("rnd%0d", it), m, nbits, {$urandom, $urandom});
    end

    // Reset in the middle of a mode-3 frame, then the rest of that frame must be ignored.
    push(3, 32'h0000A55A);
    cs[3] = 1'b0;
    tick(8);
    sclk[3] = 1'b0;
    tick(HALF);
    chk("mid.miso", miso[3], 1);
    sclk[3] = 1'b1;
    tick(HALF);
    sclk[3] = 1'b0;
    tick(2);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    for (int i = 0; i < N; i++) begin
      mrx[i]  = '0;
      mcnt[i] = 0;
    end
    tick(2);
    reset = 1'b0;
    rv0 = rxv_cnt[3];
    un0 = unr_cnt[3];
    for (int i = 0; i < 5; i++) begin
      sclk[3] = ~sclk[3];
      tick(HALF);
    end
    chk("rst.idle.miso", miso[3], 0);
    cs[3] = 1'b1;
    tick(8);
    chk("rst.tail.rxv", 64'(rxv_cnt[3] - rv0), 0);
    chk("rst.tail.unr", 64'(unr_cnt[3] - un0), 0);
    push(3, 32'h0000A55A);
    run_frame("post", 3, 16, {16'hA55A, 48'h0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_word_link.md
SPI_WORD_LINK -- requirements
Module: spi_word_link

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bits per SPI word; legal range 8..64.
REQ-002 SHALL have parameter CPOL, default 0: idle SCLK level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on first edge, 1 = sample on second edge.
REQ-004 SHALL have parameter TX_DEPTH, default 4: TX FIFO entries; power of two, 2..16.
REQ-005 SHALL have port clk, input, 1: system clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port sclk, input, 1: SPI clock from the MCU; asynchronous to clk.
REQ-008 SHALL have port cs, input, 1: chip select, active low; asynchronous to clk.
REQ-009 SHALL have port mosi, input, 1: serial data in, MSB first.
REQ-010 SHALL have port miso, output, 1: serial data out, MSB first.
REQ-011 SHALL have port rx_data, output, WORD_W: last complete received word.
REQ-012 SHALL have port rx_valid, output, 1: one-clk pulse, rx_data is new.
REQ-013 SHALL have port tx_data, input, WORD_W: word to queue for transmit.
REQ-014 SHALL have port tx_valid, input, 1: tx_data is offered.
REQ-015 SHALL have port tx_ready, output, 1: FIFO not full.
REQ-016 SHALL have port tx_underrun, output, 1: one-clk pulse, a word slot was started with the FIFO empty.

Function
REQ-017 SHALL pass sclk, cs and mosi through 2-flop synchronisers and detect sclk edges on the synchronised copies; the supported SCLK frequency is at most clk/4.
REQ-018 SHALL define sample edge = rising when CPOL==CPHA, otherwise falling; shift edge = the opposite edge.
REQ-019 SHALL use FSM states IDLE (cs high) and ACTIVE (cs low); IDLE->ACTIVE on synchronised cs fall; ACTIVE->IDLE on synchronised cs rise.
REQ-020 SHALL, in ACTIVE, shift mosi into the RX shift register on each sample edge and increment a bit counter modulo WORD_W.
REQ-021 SHALL, on the WORD_W-th sample edge, load the complete word into rx_data, including the final bit, and pulse rx_valid exactly one clk later.
REQ-022 SHALL clear the bit counter and keep receiving after a complete word, so one frame can carry any number of consecutive words.
REQ-023 SHALL discard a partial word (fewer than WORD_W bits) on cs rise: no rx_valid, and rx_data unchanged.
REQ-024 SHALL accept a TX FIFO push on a clk where tx_valid && tx_ready; tx_valid is ignored when the FIFO is full.
REQ-025 SHALL load the TX shift register by popping the FIFO head at each word start:
- CPHA=0: at the ACTIVE entry clk, and on the first shift edge after each completed word.
- CPHA=1: at the ACTIVE entry clk, and on the shift edge that follows each completed word.
REQ-026 SHALL, when a load finds the FIFO empty, load all zeros and pulse tx_underrun.
REQ-027 SHALL, when a push and an empty-FIFO load occur in the same clk, send zeros and store the pushed word for the next load.
REQ-028 SHALL drive miso from the MSB of the TX shift register and shift it left on each shift edge.
REQ-029 SHALL not shift on the CPHA=1 first shift edge of each word.
REQ-030 SHALL drive miso to 0 in IDLE, and SHALL drop a partially sent TX word on cs rise (the word is not re-queued).
REQ-031 SHALL keep tx_ready = !full, combinational from the FIFO count.

Reset
REQ-032 SHALL, on reset asserted at any time (including mid-frame), take effect immediately:
- FSM = IDLE; counters and FIFO pointers = 0.
- rx_data = 0; rx_valid = 0; tx_underrun = 0; miso = 0.
- tx_ready = 1 once the FIFO is empty.
REQ-033 SHALL ignore the remainder of any frame already in progress when reset is released; operation resumes at the next cs fall.

Structure
REQ-034 SHALL place the mode enum (MODE0..MODE3), default WORD_W and default TX_DEPTH in shared package spi_pkg.
REQ-035 SHALL implement the TX queue as sub-module spi_tx_fifo (parametrised width/depth, push/pop/full/empty/count).

Verification
REQ-036 SHALL cover: mode 0, WORD_W=32, MCU sends 0xDEADBEEF -> rx_data=0xDEADBEEF with one rx_valid pulse.
REQ-037 SHALL cover: FIFO holds 0x12345678, 0xCAFEF00D; one 64-clock frame -> miso carries both words MSB first; 2 rx_valid pulses; no underrun.
REQ-038 SHALL cover: FIFO empty at cs fall -> miso all zeros and a single tx_underrun pulse.
REQ-039 SHALL cover: push 4 words with TX_DEPTH=4 -> tx_ready low; 5th push ignored; after one word is sent, tx_ready returns high.
REQ-040 SHALL cover: cs rises after 17 bits -> no rx_valid, rx_data holds its prior value, and the next frame is received correctly.
REQ-041 SHALL cover: modes 1, 2, 3 with WORD_W=16 and 0xA55A in both directions, plus reset asserted mid-frame -> all outputs at reset values within 1 clk.
